// File: rtl/ysyx_22040386_mem_wb_stage.sv
// MEM/WB pipeline register and writeback-commit stage: register-file write port,
// retired-instruction counter and ebreak halt sequencing. Optional: WB_STALL_PROFILE_EN.
//
// state   | meaning
// RUN     | normal operation, entries commit
// DRAIN   | ebreak retired, counting down DRAIN_CYCLES, no commits
// HALTED  | terminal until reset
module ysyx_22040386_mem_wb_stage #(
   parameter int XLEN         = 64,
   parameter int CNT_W        = 64,
   parameter int DRAIN_CYCLES = 2
) (
   input  logic             i_WB_clk,
   input  logic             i_WB_rst_n,
   input  logic             i_WB_valid,
   input  logic             i_WB_stall,
   input  logic             i_WB_flush,
   input  logic             i_WB_RegWrite,
   input  logic [4:0]       i_WB_reg_wr_addr,
   input  logic [XLEN-1:0]  i_WB_reg_wr_data,
   input  logic [XLEN-1:0]  i_WB_pc,
   input  logic             i_WB_ebreak,
   output logic             o_WB_RegWrite,
   output logic [4:0]       o_WB_reg_wr_addr,
   output logic [XLEN-1:0]  o_WB_reg_wr_data,
   output logic [XLEN-1:0]  o_WB_pc,
   output logic             o_WB_commit,
   output logic [CNT_W-1:0] o_WB_inst_cnt,
   output logic             o_WB_halt,
   output logic [1:0]       o_WB_state
`ifdef WB_STALL_PROFILE_EN
   ,
   output logic [31:0]      o_WB_stall_cnt,
   output logic [31:0]      o_WB_bubble_cnt
`endif
);

   typedef enum logic [1:0] {
      S_RUN    = 2'd0,
      S_DRAIN  = 2'd1,
      S_HALTED = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [3:0]        drain_q, drain_d;
   logic              valid_q, valid_d;
   logic              committed_q, committed_d;
   logic              regwrite_q, regwrite_d;
   logic              ebreak_q, ebreak_d;
   logic [4:0]        addr_q, addr_d;
   logic [XLEN-1:0]   data_q, data_d;
   logic [XLEN-1:0]   pc_q, pc_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              commit;

   assign commit = valid_q & ~committed_q & (state_q == S_RUN);

   always_comb begin
      state_d = state_q;
      drain_d = drain_q;
      case (state_q)
         S_RUN: begin
            if (commit && ebreak_q) begin
               state_d = S_DRAIN;
               drain_d = 4'(DRAIN_CYCLES - 1);
            end
         end
         S_DRAIN: begin
            if (drain_q == 4'd0) state_d = S_HALTED;
            else                 drain_d = drain_q - 4'd1;
         end
         default: ;
      endcase
   end

   // Bubble on the next state so the entry captured alongside the ebreak commit is dropped.
   always_comb begin
      valid_d     = valid_q;
      committed_d = committed_q;
      regwrite_d  = regwrite_q;
      ebreak_d    = ebreak_q;
      addr_d      = addr_q;
      data_d      = data_q;
      pc_d        = pc_q;
      if (state_d != S_RUN || i_WB_flush) begin
         valid_d     = 1'b0;
         committed_d = 1'b0;
      end else if (i_WB_stall) begin
         committed_d = committed_q | commit;
      end else begin
         valid_d     = i_WB_valid;
         committed_d = 1'b0;
         regwrite_d  = i_WB_RegWrite;
         ebreak_d    = i_WB_ebreak;
         addr_d      = i_WB_reg_wr_addr;
         data_d      = i_WB_reg_wr_data;
         pc_d        = i_WB_pc;
      end
      cnt_d = commit ? cnt_q + CNT_W'(1) : cnt_q;
   end

   always_ff @(posedge i_WB_clk) begin
      if (!i_WB_rst_n) begin
         state_q     <= S_RUN;
         drain_q     <= 4'd0;
         valid_q     <= 1'b0;
         committed_q <= 1'b0;
         regwrite_q  <= 1'b0;
         ebreak_q    <= 1'b0;
         addr_q      <= 5'd0;
         data_q      <= '0;
         pc_q        <= '0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         drain_q     <= drain_d;
         valid_q     <= valid_d;
         committed_q <= committed_d;
         regwrite_q  <= regwrite_d;
         ebreak_q    <= ebreak_d;
         addr_q      <= addr_d;
         data_q      <= data_d;
         pc_q        <= pc_d;
         cnt_q       <= cnt_d;
      end
   end

   assign o_WB_RegWrite    = valid_q & regwrite_q & (addr_q != 5'd0);
   assign o_WB_reg_wr_addr = addr_q;
   assign o_WB_reg_wr_data = data_q;
   assign o_WB_pc          = pc_q;
   assign o_WB_commit      = commit;
   assign o_WB_inst_cnt    = cnt_q;
   assign o_WB_halt        = (state_q == S_HALTED);
   assign o_WB_state       = state_q;

`ifdef WB_STALL_PROFILE_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic [31:0] bubble_cnt_q, bubble_cnt_d;

   always_comb begin
      stall_cnt_d  = stall_cnt_q;
      bubble_cnt_d = bubble_cnt_q;
      if (state_q == S_RUN) begin
         if (i_WB_stall) stall_cnt_d  = stall_cnt_q + 32'd1;
         if (!valid_q)   bubble_cnt_d = bubble_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge i_WB_clk) begin
      if (!i_WB_rst_n) begin
         stall_cnt_q  <= 32'd0;
         bubble_cnt_q <= 32'd0;
      end else begin
         stall_cnt_q  <= stall_cnt_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign o_WB_stall_cnt  = stall_cnt_q;
   assign o_WB_bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_ysyx_22040386_mem_wb_stage.sv
// Table-driven scoreboard bench for the MEM/WB stage; a CNT_W=4 copy shares the
// stimulus to exercise counter wrap.
module tb_ysyx_22040386_mem_wb_stage;

   logic        clk = 1'b0;
   logic        rst_n, valid, stall, flush, rw, ebreak;
   logic [4:0]  addr;
   logic [63:0] data, pc;

   logic        o_rw, o_commit, o_halt;
   logic [4:0]  o_addr;
   logic [63:0] o_data, o_pc, o_cnt;
   logic [1:0]  o_state;

   logic        o4_rw, o4_commit, o4_halt;
   logic [4:0]  o4_addr;
   logic [63:0] o4_data, o4_pc;
   logic [3:0]  o4_cnt;
   logic [1:0]  o4_state;

`ifdef WB_STALL_PROFILE_EN
   logic [31:0] o_stall_cnt, o_bubble_cnt, o4_stall_cnt, o4_bubble_cnt;
`endif

   always #5 clk = ~clk;

   ysyx_22040386_mem_wb_stage dut (
      .i_WB_clk(clk), .i_WB_rst_n(rst_n), .i_WB_valid(valid), .i_WB_stall(stall),
      .i_WB_flush(flush), .i_WB_RegWrite(rw), .i_WB_reg_wr_addr(addr),
      .i_WB_reg_wr_data(data), .i_WB_pc(pc), .i_WB_ebreak(ebreak),
      .o_WB_RegWrite(o_rw), .o_WB_reg_wr_addr(o_addr), .o_WB_reg_wr_data(o_data),
      .o_WB_pc(o_pc), .o_WB_commit(o_commit), .o_WB_inst_cnt(o_cnt),
      .o_WB_halt(o_halt), .o_WB_state(o_state)
`ifdef WB_STALL_PROFILE_EN
      , .o_WB_stall_cnt(o_stall_cnt), .o_WB_bubble_cnt(o_bubble_cnt)
`endif
   );

   ysyx_22040386_mem_wb_stage #(.CNT_W(4)) dut4 (
      .i_WB_clk(clk), .i_WB_rst_n(rst_n), .i_WB_valid(valid), .i_WB_stall(stall),
      .i_WB_flush(flush), .i_WB_RegWrite(rw), .i_WB_reg_wr_addr(addr),
      .i_WB_reg_wr_data(data), .i_WB_pc(pc), .i_WB_ebreak(ebreak),
      .o_WB_RegWrite(o4_rw), .o_WB_reg_wr_addr(o4_addr), .o_WB_reg_wr_data(o4_data),
      .o_WB_pc(o4_pc), .o_WB_commit(o4_commit), .o_WB_inst_cnt(o4_cnt),
      .o_WB_halt(o4_halt), .o_WB_state(o4_state)
`ifdef WB_STALL_PROFILE_EN
      , .o_WB_stall_cnt(o4_stall_cnt), .o_WB_bubble_cnt(o4_bubble_cnt)
`endif
   );

   typedef struct {
      logic        rst_n, valid, stall, flush, rw;
      logic [4:0]  addr;
      logic [63:0] data, pc;
      logic        ebreak;
      logic        e_rw;
      logic [4:0]  e_addr;
      logic [63:0] e_data, e_pc;
      logic        e_commit;
      logic [63:0] e_cnt;
      logic [1:0]  e_state;
      logic        e_halt;
      logic        chk_data;
   } vec_t;

   vec_t vecs[$];
   vec_t sb[$];
   int   errors = 0;
   int   checks = 0;

   function automatic vec_t mk(
      input logic r, v, s, f, w, input logic [4:0] a, input logic [63:0] d, p, input logic eb,
      input logic ew, input logic [4:0] ea, input logic [63:0] ed, ep,
      input logic ec, input logic [63:0] en, input logic [1:0] es, input logic eh, input logic cd);
      vec_t t;
      t.rst_n = r; t.valid = v; t.stall = s; t.flush = f; t.rw = w;
      t.addr = a; t.data = d; t.pc = p; t.ebreak = eb;
      t.e_rw = ew; t.e_addr = ea; t.e_data = ed; t.e_pc = ep;
      t.e_commit = ec; t.e_cnt = en; t.e_state = es; t.e_halt = eh; t.chk_data = cd;
      return t;
   endfunction

   task automatic drive(input vec_t v);
      rst_n = v.rst_n; valid = v.valid; stall = v.stall; flush = v.flush; rw = v.rw;
      addr = v.addr; data = v.data; pc = v.pc; ebreak = v.ebreak;
   endtask

   task automatic check_vec(input int idx, input vec_t e);
      checks++;
      if ({o_rw, o_commit, o_cnt, o_state, o_halt} !==
          {e.e_rw, e.e_commit, e.e_cnt, e.e_state, e.e_halt}) begin
         errors++;
         $display("FAIL ctrl[%0d]: got rw=%0b commit=%0b cnt=%0d state=%0d halt=%0b, want rw=%0b commit=%0b cnt=%0d state=%0d halt=%0b",
                  idx, o_rw, o_commit, o_cnt, o_state, o_halt,
                  e.e_rw, e.e_commit, e.e_cnt, e.e_state, e.e_halt);
      end
      checks++;
      if (o4_cnt !== e.e_cnt[3:0]) begin
         errors++;
         $display("FAIL cnt4[%0d]: got %0d want %0d", idx, o4_cnt, e.e_cnt[3:0]);
      end
      if (e.chk_data) begin
         checks++;
         if ({o_addr, o_data, o_pc} !== {e.e_addr, e.e_data, e.e_pc}) begin
            errors++;
            $display("FAIL data[%0d]: got addr=%0d data=%h pc=%h, want addr=%0d data=%h pc=%h",
                     idx, o_addr, o_data, o_pc, e.e_addr, e.e_data, e.e_pc);
         end
      end
   endtask

   initial begin
      // reset, three writes, x0 write, stalled x8
      vecs.push_back(mk(0,0,0,0,0, 0,0,0,0,             0,0,0,0,           0,0,0,0,1));
      vecs.push_back(mk(1,1,0,0,1, 5,'h11,'h100,0,      1,5,'h11,'h100,    1,0,0,0,1));
      vecs.push_back(mk(1,1,0,0,1, 6,'h22,'h104,0,      1,6,'h22,'h104,    1,1,0,0,1));
      vecs.push_back(mk(1,1,0,0,1, 7,'h33,'h108,0,      1,7,'h33,'h108,    1,2,0,0,1));
      vecs.push_back(mk(1,1,0,0,1, 0,'hDEAD,'h10C,0,    0,0,'hDEAD,'h10C,  1,3,0,0,1));
      vecs.push_back(mk(1,1,0,0,1, 8,'h44,'h110,0,      1,8,'h44,'h110,    1,4,0,0,1));
      for (int i = 0; i < 4; i++)
         vecs.push_back(mk(1,1,1,0,1, 10,'h99,'h114,0,  1,8,'h44,'h110,    0,5,0,0,1));
      vecs.push_back(mk(1,0,0,0,0, 0,0,0,0,             0,0,0,0,           0,5,0,0,0));
      // flush+stall, then flush alone with a committing entry
      vecs.push_back(mk(1,1,0,0,1, 11,'h55,'h118,0,     1,11,'h55,'h118,   1,5,0,0,1));
      vecs.push_back(mk(1,1,1,1,1, 12,'h66,'h11C,0,     0,0,0,0,           0,6,0,0,0));
      vecs.push_back(mk(1,1,0,0,1, 13,'h77,'h120,0,     1,13,'h77,'h120,   1,6,0,0,1));
      vecs.push_back(mk(1,1,0,1,1, 14,'h88,'h124,0,     0,0,0,0,           0,7,0,0,0));
      // ebreak then x9 writes that must never retire
      vecs.push_back(mk(1,1,0,0,0, 0,0,'h80000010,1,    0,0,0,'h80000010,  1,7,0,0,1));
      vecs.push_back(mk(1,1,0,0,1, 9,'hBB,'h80000014,0, 0,0,0,0,           0,8,1,0,0));
      vecs.push_back(mk(1,1,0,0,1, 9,'hBB,'h80000014,0, 0,0,0,0,           0,8,1,0,0));
      vecs.push_back(mk(1,1,0,0,1, 9,'hBB,'h80000014,0, 0,0,0,0,           0,8,2,1,0));
      vecs.push_back(mk(1,1,0,0,1, 9,'hBB,'h80000014,0, 0,0,0,0,           0,8,2,1,0));
      vecs.push_back(mk(0,1,0,0,1, 9,'hBB,'h80000014,0, 0,0,0,0,           0,0,0,0,1));
      // ebreak committing while stalled still drains
      vecs.push_back(mk(1,1,0,0,0, 0,0,'h200,1,         0,0,0,'h200,       1,0,0,0,1));
      vecs.push_back(mk(1,0,1,0,0, 0,0,0,0,             0,0,0,0,           0,1,1,0,0));
      vecs.push_back(mk(1,0,0,0,0, 0,0,0,0,             0,0,0,0,           0,1,1,0,0));
      vecs.push_back(mk(1,0,0,0,0, 0,0,0,0,             0,0,0,0,           0,1,2,1,0));
      vecs.push_back(mk(0,0,0,0,0, 0,0,0,0,             0,0,0,0,           0,0,0,0,1));

      drive(vecs[0]);
      @(negedge clk);
      foreach (vecs[i]) begin
         drive(vecs[i]);
         sb.push_back(vecs[i]);
         @(negedge clk);
         check_vec(i, sb.pop_front());
      end

      // counter wrap: back-to-back commits, CNT_W=4 copy goes 15 -> 0
      rst_n = 1; valid = 1; stall = 0; flush = 0; rw = 1; addr = 1; ebreak = 0;
      for (int k = 0; k < 18; k++) begin
         data = 64'(k); pc = 64'('h400 + 4 * k);
         @(negedge clk);
         checks++;
         if (o_cnt !== 64'(k) || o4_cnt !== 4'(k) || o_commit !== 1'b1) begin
            errors++;
            $display("FAIL wrap[%0d]: got cnt=%0d cnt4=%0d commit=%0b, want cnt=%0d cnt4=%0d commit=1",
                     k, o_cnt, o4_cnt, o_commit, k, k % 16);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ysyx_22040386_mem_wb_stage.md
Name: ysyx_22040386_mem_wb_stage

Overview:
- MEM/WB pipeline register and writeback-commit stage, directly downstream of the memory-access stage.
- Registers the memory stage's final write-back result, pc and control bits.
- Drives the register-file write port and the MEM_WB forwarding taps consumed by the forwarding control.
- Counts retired instructions and runs the ebreak halt sequence for the simulation environment.

Parameters:
- XLEN, 64, datapath width of write data and pc.
- CNT_W, 64, width of the retired-instruction counter.
- DRAIN_CYCLES, 2, cycles spent in DRAIN after an ebreak commits before HALTED; legal range 1..15.

Ports:
- i_WB_clk  input  1  clock; all state updates on its rising edge.
- i_WB_rst_n  input  1  synchronous, active-low reset.
- i_WB_valid  input  1  memory stage presents a real instruction this cycle.
- i_WB_stall  input  1  hold the stage register (hazard unit).
- i_WB_flush  input  1  load a bubble into the stage register.
- i_WB_RegWrite  input  1  instruction writes rd.
- i_WB_reg_wr_addr  input  5  rd index.
- i_WB_reg_wr_data  input  XLEN  final write-back data (load result or ALU/link value).
- i_WB_pc  input  XLEN  pc of the instruction.
- i_WB_ebreak  input  1  instruction is ebreak.
- o_WB_RegWrite  output  1  register-file write enable; also the MEM_WB RegWrite forwarding tap.
- o_WB_reg_wr_addr  output  5  register-file write index; also a forwarding tap.
- o_WB_reg_wr_data  output  XLEN  register-file write data; also a forwarding tap.
- o_WB_pc  output  XLEN  pc of the entry currently held.
- o_WB_commit  output  1  one-cycle pulse per retired instruction.
- o_WB_inst_cnt  output  CNT_W  retired-instruction count.
- o_WB_halt  output  1  high in HALTED.
- o_WB_state  output  2  current FSM state: RUN=0, DRAIN=1, HALTED=2.

Behaviour:
- Reset (i_WB_rst_n=0 at a clock edge):
  - valid_q=0, committed_q=0, all data registers 0, inst_cnt=0, state=RUN, drain counter 0.
  - Consequently every output is 0.
- Stage register update, evaluated each edge in priority order:
  1. reset;
  2. state!=RUN: load a bubble (valid_q=0);
  3. i_WB_flush: load a bubble; flush wins over stall;
  4. i_WB_stall: hold all fields;
  5. otherwise capture every input, with valid_q=i_WB_valid and committed_q=0.
- Outputs (latency 1 cycle from input to output):
  - o_WB_RegWrite = valid_q & RegWrite_q & (wr_addr_q!=0). Writes to x0 are suppressed.
  - Data, address and pc outputs drive the register contents directly; they are valid even when o_WB_RegWrite=0.
- Commit:
  - o_WB_commit = valid_q & ~committed_q & (state==RUN).
  - On a commit, committed_q is set at the edge, so a stalled entry retires exactly once.
  - A held entry keeps re-asserting o_WB_RegWrite; this is an idempotent write.
  - inst_cnt increments on each commit and wraps from all-ones to 0.
- FSM:
  - RUN -> DRAIN on a commit whose ebreak_q=1; drain counter loads DRAIN_CYCLES-1.
  - DRAIN: decrement the counter each cycle; at counter 0 go to HALTED.
  - HALTED: terminal. Only reset leaves it.
  - In DRAIN and HALTED: no commits; the register is forced to bubbles, so o_WB_RegWrite=0 from the first DRAIN cycle.
  - Instructions arriving after an ebreak never retire.
- Simultaneous events:
  - Ebreak commit with i_WB_stall=1: the transition to DRAIN still occurs.
  - Reset during DRAIN or HALTED returns to RUN with the counter cleared.
  - Flush with valid_q=1 and committed_q=0 while not stalled: the current entry still commits this cycle, because the commit is combinational from the register; the bubble loads at the edge.

Optional Feature:
- Macro: WB_STALL_PROFILE_EN.
- When defined, two extra outputs exist:
  - o_WB_stall_cnt (32 bits): +1 on every cycle with state==RUN and i_WB_stall=1.
  - o_WB_bubble_cnt (32 bits): +1 on every RUN cycle with valid_q=0.
- Both counters reset to 0, wrap at 2^32, and freeze outside RUN.
- When not defined, these ports and their logic are absent and all other behaviour is identical.

Test Plan:
- Reset then 3 back-to-back valid writes (x5=0x11, x6=0x22, x7=0x33) -> each appears on the write port one cycle later; 3 commit pulses; inst_cnt=3.
- Valid write to x0 with data 0xDEAD -> o_WB_RegWrite=0, o_WB_commit=1, inst_cnt increments.
- Entry x8=0x44 captured, then i_WB_stall held 4 cycles -> o_WB_RegWrite=1 for 5 cycles; exactly one commit pulse; inst_cnt +1.
- Flush and stall together with a valid input pending -> bubble loaded next cycle (o_WB_RegWrite=0, no commit).
- Ebreak at pc 0x80000010 followed by valid writes to x9 -> one commit for the ebreak; state sequence RUN, DRAIN, DRAIN, HALTED; o_WB_halt=1; x9 never written; inst_cnt frozen.
- Preload inst_cnt near wrap (force or long run with CNT_W=4) -> 15 then 0 on the next commit; reset in HALTED -> state=RUN, all outputs 0.
